gpio_pin_filter: RTL and testbench
==================================

# gpio_pin_filter

Input conditioning stage directly upstream of the GPIO peripheral. Two asynchronous pad inputs pass through a two-flop synchronizer and a per-pin debounce filter, and the result drives the GPIO block's `io_pin[1:0]` input. The block also produces one-cycle edge strobes and, optionally, sticky per-pin edge-interrupt flags plus a combined request for the core's external-interrupt input.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronized cycles a new level must hold before it is accepted. Legal range is 1 to 2^`CNT_W`−1.
- `CNT_W`, default 5: width of each per-pin debounce counter.

**Ports**
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `pin_raw`, input, 2: asynchronous pad levels.
- `irq_en`, input, 2: per-pin interrupt enable (level).
- `irq_clr`, input, 2: per-pin pending-clear strobe (one cycle).
- `io_pin`, output, 2: debounced pin levels, fed to the GPIO block.
- `edge_rise`, output, 2: one-cycle strobe when `io_pin[i]` goes 0→1.
- `edge_fall`, output, 2: one-cycle strobe when `io_pin[i]` goes 1→0.
- `irq_pending`, output, 2: sticky per-pin edge flags.
- `irq`, output, 1: OR of `irq_pending`.

## Operation

**Synchronizer**
- Per pin: `s1[i]` <= `pin_raw[i]`, then `s[i]` <= `s1[i]`.
- Only `s` is used downstream.

**Debounce FSM** (one per pin, independent)
- IDLE (`s[i]==io_pin[i]`, `cnt==0`):
  - If `s[i]!=io_pin[i]`, go to COUNT with `cnt<=1`.
  - For `DEBOUNCE_CYCLES==1`, instead accept immediately (see below).
- COUNT:
  - If `s[i]==io_pin[i]`, the glitch ended: go to IDLE and set `cnt<=0`.
  - Else if `cnt==DEBOUNCE_CYCLES-1`, accept: `io_pin[i]<=s[i]`, `cnt<=0`, go to IDLE.
  - Else `cnt<=cnt+1`.
- The counter never wraps. It saturates by construction because the terminal count forces a return to IDLE.

**Edge strobes**
- Registered together with the `io_pin` update.
- `edge_rise[i]` is high in exactly the cycle where `io_pin[i]` first reads 1. `edge_fall[i]` is the same for 0.
- Both are low otherwise. They are never high together for the same pin.

**Pending flags** (macro-controlled, see Configuration)
- Set: `irq_pending[i]` <= 1 on a cycle where (`edge_rise[i]|edge_fall[i]`) and `irq_en[i]`. The set is based on the strobe and is visible one cycle after the strobe.
- Clear: `irq_pending[i]` <= 0 when `irq_clr[i]` is high.
- Set and clear in the same cycle: set wins, and the flag stays 1.
- Deasserting `irq_en[i]` does not clear an already-pending flag.
- `irq` is combinational OR of `irq_pending`.

**Reset** (synchronous, on any cycle, including mid-count)
- Cleared to 0: `s1`, `s`, `cnt`, `io_pin`, `edge_rise`, `edge_fall`, `irq_pending`.
- `irq` is therefore 0.
- If a pad is high when reset releases, it is filtered normally. `io_pin` rises after the full latency and produces a real `edge_rise`.

## Timing

- **Raw to `io_pin` latency:** a clean level change on `pin_raw` sampled at edge k appears on `io_pin` after edge k+1+`DEBOUNCE_CYCLES`. That is 2 synchronizer cycles plus `DEBOUNCE_CYCLES`, minus overlap, giving `DEBOUNCE_CYCLES`+2 cycles counted from the sampling edge. With the default of 16, this is 18 cycles.
- **Glitch rejection:** any synchronized pulse shorter than `DEBOUNCE_CYCLES` cycles produces no change on `io_pin` and no strobe.
- **Strobe to flag:** `irq_pending` and `irq` rise one cycle after the edge strobe.
- **Clear:** `irq_clr` takes effect on the next edge, and `irq` drops the same cycle.
- **Pin independence:** the two pins share no state. Simultaneous transitions on both pins are handled fully in parallel.

## Configuration

Macro `GPIO_PIN_FILTER_IRQ_EN` (in defines).

- **Defined:** the pending flags and `irq` behave as specified above.
- **Undefined:**
  - `irq_pending` and `irq` are constant 0.
  - `irq_en` and `irq_clr` are ignored; the ports remain for a stable interface.
  - The synchronizer, debounce logic and edge strobes are unchanged.

## Test plan

All scenarios use `DEBOUNCE_CYCLES=4` and `irq_en=2'b11`, with the macro defined unless stated.

1. **Reset behaviour:** hold `rst_n=0` for 3 cycles with `pin_raw=2'b11`, then release.
   - During reset, all outputs are 0.
   - Six cycles after release, `io_pin=2'b11` with a one-cycle `edge_rise=2'b11`.
   - One cycle later, `irq_pending=2'b11` and `irq=1`.
2. **Glitch rejection:** with `io_pin[0]=0`, pulse `pin_raw[0]` high for 3 cycles.
   - `io_pin[0]` stays 0 and `edge_rise[0]` stays 0.
   - A 4-cycle pulse that is then held high gives `io_pin[0]=1` 6 cycles after onset.
3. **Falling edge and clear:** drop `pin_raw[1]` from 1 to 0.
   - `edge_fall[1]` pulses 6 cycles later, and `irq_pending[1]=1` on the next cycle.
   - Pulsing `irq_clr[1]` gives `irq_pending[1]=0` on the next cycle.
4. **Set versus clear collision:** assert `irq_clr[0]` in the same cycle as a pending set on pin 0.
   - `irq_pending[0]` remains 1.
5. **Reset mid-count:** start a transition on pin 0 and assert `rst_n=0` at count 2.
   - `cnt`, `io_pin` and the strobes are 0 after that edge.
   - After release, the transition re-filters over the full 6 cycles.
6. **Macro undefined:** repeat scenario 3.
   - Edge strobes are unchanged.
   - `irq_pending` and `irq` stay 0 throughout.

Source files
------------

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter
//   Conditions two asynchronous pad inputs for the GPIO block: a two-flop
//   synchronizer, an independent debounce filter per pin, registered
//   one-cycle edge strobes and, optionally, sticky per-pin edge-interrupt
//   flags with a combined request line.
//
//   Optional feature macro: GPIO_PIN_FILTER_IRQ_EN
//     defined   -> irq_pending / irq are live, irq_en / irq_clr are honoured
//     undefined -> irq_pending / irq tie to 0, irq_en / irq_clr are ignored
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive synchronized cycles a new level must hold
//                     before it is accepted (1 .. 2**CNT_W-1)
//   CNT_W           : width of each per-pin debounce counter
//
// Ports
//   clk         : single clock
//   rst_n       : synchronous, active-low reset
//   pin_raw     : asynchronous pad levels
//   irq_en      : per-pin interrupt enable (level)
//   irq_clr     : per-pin pending-clear strobe
//   io_pin      : debounced pin levels
//   edge_rise   : one-cycle strobe, io_pin[i] went 0->1
//   edge_fall   : one-cycle strobe, io_pin[i] went 1->0
//   irq_pending : sticky per-pin edge flags
//   irq         : OR of irq_pending
module gpio_pin_filter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] pin_raw,
  input  logic [1:0] irq_en,
  input  logic [1:0] irq_clr,
  output logic [1:0] io_pin,
  output logic [1:0] edge_rise,
  output logic [1:0] edge_fall,
  output logic [1:0] irq_pending,
  output logic       irq
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Count value on which the new level has been seen DEBOUNCE_CYCLES times.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]            s1_q;
  logic [1:0]            s_q;
  logic [1:0]            state_q, state_d;
  logic [1:0][CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]            io_q,    io_d;
  logic [1:0]            rise_q,  rise_d;
  logic [1:0]            fall_q,  fall_d;

  // Two-flop synchronizer for both pads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 2'b00;
      s_q  <= 2'b00;
    end else begin
      s1_q <= pin_raw;
      s_q  <= s1_q;
    end
  end

  // Per-pin debounce FSM next-state; an accepted level also produces the
  // matching edge strobe so both become visible on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    io_d    = io_q;
    rise_d  = 2'b00;
    fall_d  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (s_q[i] != io_q[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              // A single differing cycle is already enough.
              io_d[i]   = s_q[i];
              rise_d[i] = s_q[i];
              fall_d[i] = ~s_q[i];
              cnt_d[i]  = CNT_ZERO;
            end else begin
              state_d[i] = ST_COUNT;
              cnt_d[i]   = CNT_ONE;
            end
          end else begin
            cnt_d[i] = CNT_ZERO;
          end
        end
        ST_COUNT: begin
          if (s_q[i] == io_q[i]) begin
            // Glitch ended before acceptance: start over.
            state_d[i] = ST_IDLE;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] == CNT_TERM) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = CNT_ZERO;
            io_d[i]    = s_q[i];
            rise_d[i]  = s_q[i];
            fall_d[i]  = ~s_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = CNT_ZERO;
        end
      endcase
    end
  end

  // Debounce state, filtered levels and edge strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= {ST_IDLE, ST_IDLE};
      cnt_q   <= {CNT_ZERO, CNT_ZERO};
      io_q    <= 2'b00;
      rise_q  <= 2'b00;
      fall_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      io_q    <= io_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign io_pin    = io_q;
  assign edge_rise = rise_q;
  assign edge_fall = fall_q;

`ifdef GPIO_PIN_FILTER_IRQ_EN
  logic [1:0] pend_q, pend_d;

  // Sticky flags: a strobe on an enabled pin sets, irq_clr clears, set wins.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < 2; i++) begin
      if ((rise_q[i] | fall_q[i]) && irq_en[i]) begin
        pend_d[i] = 1'b1;
      end else if (irq_clr[i]) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
  end

  // Pending flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 2'b00;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign irq_pending = pend_q;
  assign irq         = |pend_q;
`else
  // Interrupt inputs are kept on the port list but have no function here.
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_en, irq_clr};

  assign irq_pending = 2'b00;
  assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_pin_filter.sv
// Self-checking bench for gpio_pin_filter with DEBOUNCE_CYCLES=4.
// A window-based reference model (a pin flips once its last DB synchronized
// samples all disagree with the current level) is compared every cycle on
// the falling clock edge; directed scenarios add literal expectations.
module tb_gpio_pin_filter;

  localparam int DB = 4;
  localparam logic [7:0] WMASK = 8'h0F;
`ifdef GPIO_PIN_FILTER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pin_raw, irq_en, irq_clr;
  logic [1:0] io_pin, edge_rise, edge_fall, irq_pending;
  logic       irq;

  int compared   = 0;
  int mismatched = 0;

  gpio_pin_filter #(.DEBOUNCE_CYCLES(DB), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .pin_raw(pin_raw), .irq_en(irq_en),
    .irq_clr(irq_clr), .io_pin(io_pin), .edge_rise(edge_rise),
    .edge_fall(edge_fall), .irq_pending(irq_pending), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Reference model state (expected outputs after the latest rising edge).
  logic [1:0] m_s1 = 2'b00, m_s = 2'b00, m_io = 2'b00;
  logic [1:0] m_rise = 2'b00, m_fall = 2'b00, m_pend = 2'b00;
  logic [7:0] m_hist [2] = '{8'h00, 8'h00};
  int         m_hcnt [2] = '{0, 0};

  // Compare process: check, then advance the model with the inputs that the
  // next rising edge will sample (inputs only change at posedge+2).
  initial begin
    logic [1:0] p, nr, nf;
    logic [7:0] win;
    forever begin
      @(negedge clk);
      chk("io_pin",      io_pin,      m_io);
      chk("edge_rise",   edge_rise,   m_rise);
      chk("edge_fall",   edge_fall,   m_fall);
      chk("irq_pending", irq_pending, m_pend);
      chk("irq",         {1'b0, irq}, {1'b0, |m_pend});
      if (!rst_n) begin
        m_s1 = 2'b00; m_s = 2'b00; m_io = 2'b00;
        m_rise = 2'b00; m_fall = 2'b00; m_pend = 2'b00;
        for (int i = 0; i < 2; i++) begin
          m_hist[i] = 8'h00;
          m_hcnt[i] = 0;
        end
      end else begin
        p = m_pend;
        for (int i = 0; i < 2; i++) begin
          if (IRQ_ON && (m_rise[i] | m_fall[i]) && irq_en[i]) p[i] = 1'b1;
          else if (IRQ_ON && irq_clr[i]) p[i] = 1'b0;
        end
        if (!IRQ_ON) p = 2'b00;
        nr = 2'b00;
        nf = 2'b00;
        for (int i = 0; i < 2; i++) begin
          m_hist[i] = {m_hist[i][6:0], m_s[i]};
          if (m_hcnt[i] < DB) m_hcnt[i]++;
          win = m_hist[i] & WMASK;
          if (m_hcnt[i] >= DB &&
              ((m_io[i] == 1'b0 && win == WMASK) || (m_io[i] == 1'b1 && win == 8'h00))) begin
            m_io[i] = ~m_io[i];
            nr[i]   = m_io[i];
            nf[i]   = ~m_io[i];
          end
        end
        m_rise = nr;
        m_fall = nf;
        m_pend = p;
        m_s    = m_s1;
        m_s1   = pin_raw;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; pin_raw = 2'b11; irq_en = 2'b11; irq_clr = 2'b00;

    // 1: reset with pads high, then full-latency rise on both pins.
    tick(3);
    chk("rst_io", io_pin, 2'b00);
    chk("rst_rise", edge_rise, 2'b00);
    chk("rst_pend", irq_pending, 2'b00);
    chk("rst_irq", {1'b0, irq}, 2'b00);
    rst_n = 1'b1;
    tick(5);
    chk("s1_io_early", io_pin, 2'b00);
    tick(1);
    chk("s1_io", io_pin, 2'b11);
    chk("s1_rise", edge_rise, 2'b11);
    tick(1);
    chk("s1_rise_off", edge_rise, 2'b00);
    chk("s1_pend", irq_pending, IRQ_ON ? 2'b11 : 2'b00);
    chk("s1_irq", {1'b0, irq}, {1'b0, IRQ_ON});
    irq_clr = 2'b11;
    tick(1);
    irq_clr = 2'b00;
    chk("s1_clr", irq_pending, 2'b00);

    // 2: bring pin0 low, then glitch rejection and accepted pulse.
    pin_raw = 2'b10;
    tick(6);
    chk("s2_io_low", io_pin, 2'b10);
    chk("s2_fall", edge_fall, 2'b01);
    tick(1);
    chk("s2_pend", irq_pending, IRQ_ON ? 2'b01 : 2'b00);
    irq_clr = 2'b01;
    tick(1);
    irq_clr = 2'b00;
    chk("s2_clr", irq_pending, 2'b00);
    pin_raw = 2'b11;
    tick(3);
    pin_raw = 2'b10;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("s2_glitch_io", io_pin, 2'b10);
      chk("s2_glitch_rise", edge_rise, 2'b00);
    end
    pin_raw = 2'b11;
    tick(5);
    chk("s2_hold_io_early", io_pin, 2'b10);
    tick(1);
    chk("s2_hold_io", io_pin, 2'b11);
    chk("s2_hold_rise", edge_rise, 2'b01);
    tick(1);
    chk("s2_hold_pend", irq_pending, IRQ_ON ? 2'b01 : 2'b00);
    irq_clr = 2'b01;
    tick(1);
    irq_clr = 2'b00;

    // 3: falling edge on pin1 and clear.
    pin_raw = 2'b01;
    tick(6);
    chk("s3_io", io_pin, 2'b01);
    chk("s3_fall", edge_fall, 2'b10);
    tick(1);
    chk("s3_fall_off", edge_fall, 2'b00);
    chk("s3_pend", irq_pending, IRQ_ON ? 2'b10 : 2'b00);
    irq_clr = 2'b10;
    tick(1);
    irq_clr = 2'b00;
    chk("s3_clr", irq_pending, 2'b00);
    chk("s3_irq", {1'b0, irq}, 2'b00);

    // 4: clear collides with a pending set on pin0: set wins.
    pin_raw = 2'b00;
    tick(6);
    chk("s4_fall", edge_fall, 2'b01);
    irq_clr = 2'b01;
    tick(1);
    irq_clr = 2'b00;
    chk("s4_collide", irq_pending, IRQ_ON ? 2'b01 : 2'b00);
    irq_clr = 2'b01;
    tick(1);
    irq_clr = 2'b00;
    chk("s4_clr", irq_pending, 2'b00);

    // 5: reset at count 2, then full re-filter; enable gating of the flag.
    pin_raw = 2'b01;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    chk("s5_rst_io", io_pin, 2'b00);
    chk("s5_rst_rise", edge_rise, 2'b00);
    rst_n = 1'b1;
    tick(5);
    chk("s5_io_early", io_pin, 2'b00);
    tick(1);
    chk("s5_io", io_pin, 2'b01);
    chk("s5_rise", edge_rise, 2'b01);
    tick(1);
    chk("s5_pend", irq_pending, IRQ_ON ? 2'b01 : 2'b00);
    irq_en = 2'b00;
    tick(2);
    chk("s5_pend_kept", irq_pending, IRQ_ON ? 2'b01 : 2'b00);
    irq_clr = 2'b01;
    tick(1);
    irq_clr = 2'b00;
    pin_raw = 2'b00;
    tick(6);
    chk("s5_fall_dis", edge_fall, 2'b01);
    tick(1);
    chk("s5_pend_dis", irq_pending, 2'b00);
    irq_en = 2'b11;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
